// File: rtl/writeback_stage.sv
// ============================================================================
//  Module      : writeback_stage
//  Description : Final stage of the MIPS pipeline. It holds one instruction
//                handed over by the memory stage and is the only writer of
//                the register file write port. For loads it waits for the
//                data SRAM response, then aligns and extends the read word.
//                LWL and LWR produce per-byte write strobes so that the
//                register file can merge partial words.
//                It also drives the decode-stage bypass/stall signals and
//                the debug trace port.
//
//  Ports
//    clock, reset          rising-edge clock, synchronous active-high reset
//    mem_to_wb_valid       memory stage offers an instruction
//    wb_allow_in           this stage accepts an instruction this cycle
//    mem_pc/dest/gpr_write/result/load_op
//                          instruction fields (result is the byte address
//                          for loads)
//    data_data_ok/rdata    data SRAM read response
//    write_*               register file write port
//    wb_bypass_*           forwarding and stall information for decode
//    debug_wb_*            trace port
//
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module writeback_stage #(
    parameter bit BYPASS_ENABLE = 1'b1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        mem_to_wb_valid,
    output logic        wb_allow_in,
    input  logic [31:0] mem_pc,
    input  logic [4:0]  mem_dest,
    input  logic        mem_gpr_write,
    input  logic [31:0] mem_result,
    input  logic [2:0]  mem_load_op,

    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,

    output logic        write_enabled,
    output logic [4:0]  write_address,
    output logic [3:0]  write_strobe,
    output logic [31:0] write_data,

    output logic        wb_bypass_valid,
    output logic [4:0]  wb_bypass_dest,
    output logic [31:0] wb_bypass_data,
    output logic        wb_bypass_stall,

    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    // Load operation encoding as delivered by the memory stage.
    localparam logic [2:0] c_LD_NONE = 3'd0;
    localparam logic [2:0] c_LD_LB   = 3'd1;
    localparam logic [2:0] c_LD_LBU  = 3'd2;
    localparam logic [2:0] c_LD_LH   = 3'd3;
    localparam logic [2:0] c_LD_LHU  = 3'd4;
    localparam logic [2:0] c_LD_LW   = 3'd5;
    localparam logic [2:0] c_LD_LWL  = 3'd6;
    localparam logic [2:0] c_LD_LWR  = 3'd7;

    // ------------------------------------------------------------------
    // Stage register
    // ------------------------------------------------------------------
    logic        r_wb_valid;
    logic [31:0] r_pc;
    logic [4:0]  r_dest;
    logic        r_gpr_write;
    logic [31:0] r_result;
    logic [2:0]  r_load_op;

    logic        w_is_load;
    logic        w_ready_go;
    logic        w_retire;
    logic        w_allow_in;

    assign w_is_load  = (r_load_op != c_LD_NONE);
    assign w_ready_go = !w_is_load || data_data_ok;
    assign w_retire   = r_wb_valid && w_ready_go;
    assign w_allow_in = !r_wb_valid || w_ready_go;

    // A retiring instruction is replaced at the same edge by the incoming
    // one, so a stream of non-loads flows with no bubble. Fields only load
    // when something is actually offered; otherwise they keep their value.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wb_valid  <= 1'b0;
            r_pc        <= 32'd0;
            r_dest      <= 5'd0;
            r_gpr_write <= 1'b0;
            r_result    <= 32'd0;
            r_load_op   <= c_LD_NONE;
        end else if (w_allow_in) begin
            r_wb_valid <= mem_to_wb_valid;
            if (mem_to_wb_valid) begin
                r_pc        <= mem_pc;
                r_dest      <= mem_dest;
                r_gpr_write <= mem_gpr_write;
                r_result    <= mem_result;
                r_load_op   <= mem_load_op;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load alignment and extension
    // ------------------------------------------------------------------
    logic [1:0]  w_addr_lo;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;

    assign w_addr_lo = r_result[1:0];

    always_comb begin
        w_byte = data_rdata[7:0];
        case (w_addr_lo)
            2'd0: w_byte = data_rdata[7:0];
            2'd1: w_byte = data_rdata[15:8];
            2'd2: w_byte = data_rdata[23:16];
            2'd3: w_byte = data_rdata[31:24];
            default: w_byte = data_rdata[7:0];
        endcase
    end

    // Halfword loads are aligned upstream, so only address bit 1 matters.
    assign w_half = w_addr_lo[1] ? data_rdata[31:16] : data_rdata[15:0];

    // LWL shifts left by 8*(3-a); for a 2-bit a, 3-a is simply ~a.
    always_comb begin
        w_wdata = r_result;
        w_wstrb = 4'b1111;
        case (r_load_op)
            c_LD_NONE: w_wdata = r_result;
            c_LD_LB:   w_wdata = {{24{w_byte[7]}}, w_byte};
            c_LD_LBU:  w_wdata = {24'd0, w_byte};
            c_LD_LH:   w_wdata = {{16{w_half[15]}}, w_half};
            c_LD_LHU:  w_wdata = {16'd0, w_half};
            c_LD_LW:   w_wdata = data_rdata;
            c_LD_LWL: begin
                w_wdata = data_rdata << {~w_addr_lo, 3'b000};
                w_wstrb = 4'b1111 << ~w_addr_lo;
            end
            c_LD_LWR: begin
                w_wdata = data_rdata >> {w_addr_lo, 3'b000};
                w_wstrb = 4'b1111 >> w_addr_lo;
            end
            default: begin
                w_wdata = r_result;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register file write port
    // ------------------------------------------------------------------
    // Writes to $0 are presented as-is; the register file drops them.
    assign write_enabled = w_retire && r_gpr_write;
    assign write_address = r_dest;
    assign write_strobe  = w_wstrb;
    assign write_data    = w_wdata;

    // ------------------------------------------------------------------
    // Bypass to decode
    // ------------------------------------------------------------------
    logic w_bypass_valid;
    assign w_bypass_valid = r_wb_valid && r_gpr_write && (r_dest != 5'd0);

    generate
        if (BYPASS_ENABLE) begin : g_bypass
            assign wb_bypass_valid = w_bypass_valid;
        end else begin : g_no_bypass
            assign wb_bypass_valid = 1'b0;
        end
    endgenerate

    assign wb_bypass_dest = r_dest;
    assign wb_bypass_data = w_wdata;

    // A partial-word load only produces some bytes of the result, so it can
    // never be forwarded: decode stalls and rereads the merged register.
    assign wb_bypass_stall = wb_bypass_valid && w_is_load &&
                             (!data_data_ok ||
                              (r_load_op == c_LD_LWL) ||
                              (r_load_op == c_LD_LWR));

    assign wb_allow_in = w_allow_in;

    // ------------------------------------------------------------------
    // Debug trace
    // ------------------------------------------------------------------
    assign debug_wb_pc       = r_pc;
    assign debug_wb_rf_wen   = write_enabled ? w_wstrb : 4'b0000;
    assign debug_wb_rf_wnum  = r_dest;
    assign debug_wb_rf_wdata = w_wdata;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
//  Module      : tb_writeback_stage
//  Description : Self-checking bench for writeback_stage. A stimulus process
//                keeps a one-slot reference of the held instruction, pushes
//                expected register-file writes into a scoreboard queue and
//                checks handshake/bypass signals; a monitor pops and compares
//                every write the DUT presents.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_writeback_stage;

    logic        clk;
    logic        reset;
    logic        mem_to_wb_valid;
    logic        wb_allow_in;
    logic [31:0] mem_pc;
    logic [4:0]  mem_dest;
    logic        mem_gpr_write;
    logic [31:0] mem_result;
    logic [2:0]  mem_load_op;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        write_enabled;
    logic [4:0]  write_address;
    logic [3:0]  write_strobe;
    logic [31:0] write_data;
    logic        wb_bypass_valid;
    logic [4:0]  wb_bypass_dest;
    logic [31:0] wb_bypass_data;
    logic        wb_bypass_stall;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    writeback_stage #(.BYPASS_ENABLE(1'b1)) dut (
        .clock             (clk),
        .reset             (reset),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .wb_allow_in       (wb_allow_in),
        .mem_pc            (mem_pc),
        .mem_dest          (mem_dest),
        .mem_gpr_write     (mem_gpr_write),
        .mem_result        (mem_result),
        .mem_load_op       (mem_load_op),
        .data_data_ok      (data_data_ok),
        .data_rdata        (data_rdata),
        .write_enabled     (write_enabled),
        .write_address     (write_address),
        .write_strobe      (write_strobe),
        .write_data        (write_data),
        .wb_bypass_valid   (wb_bypass_valid),
        .wb_bypass_dest    (wb_bypass_dest),
        .wb_bypass_data    (wb_bypass_data),
        .wb_bypass_stall   (wb_bypass_stall),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    bit done   = 1'b0;

    // Reference model: the instruction currently held in the stage.
    logic        m_valid;
    logic [31:0] m_pc;
    logic [4:0]  m_dest;
    logic        m_gw;
    logic [31:0] m_res;
    logic [2:0]  m_op;

    logic [3:0] lwl_s [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    logic [3:0] lwr_s [4] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Load result from the ISA rules: pick byte/half by address, extend, or
    // shift the word for the unaligned-load pair.
    function automatic void ref_wb(input logic [2:0] op, input logic [31:0] res,
                                   input logic [31:0] d,
                                   output logic [31:0] data, output logic [3:0] s);
        int a;
        logic [7:0]  b;
        logic [15:0] h;
        a = int'(res[1:0]);
        b = 8'(d >> (8 * a));
        h = 16'(d >> (16 * (a / 2)));
        s = 4'hF;
        data = res;
        case (op)
            3'd1: data = b[7] ? {24'hFFFFFF, b} : {24'h0, b};
            3'd2: data = {24'h0, b};
            3'd3: data = h[15] ? {16'hFFFF, h} : {16'h0, h};
            3'd4: data = {16'h0, h};
            3'd5: data = d;
            3'd6: begin data = d << (8 * (3 - a)); s = lwl_s[a]; end
            3'd7: begin data = d >> (8 * a);       s = lwr_s[a]; end
            default: data = res;
        endcase
    endfunction

    // One clock cycle: drive inputs after the edge, predict, check at the
    // falling edge, then advance the reference to the next edge.
    task automatic cycle(input logic rst, input logic v, input logic [31:0] pc,
                         input logic [4:0] dest, input logic gw, input logic [31:0] res,
                         input logic [2:0] op, input logic ok, input logic [31:0] rd);
        logic is_load, ready, retire, allow, bv, stall;
        logic [31:0] d;
        logic [3:0]  s;
        @(posedge clk);
        #1;
        reset           = rst;
        mem_to_wb_valid = v;
        mem_pc          = pc;
        mem_dest        = dest;
        mem_gpr_write   = gw;
        mem_result      = res;
        mem_load_op     = op;
        data_data_ok    = ok;
        data_rdata      = rd;

        is_load = (m_op != 3'd0);
        ready   = !is_load || ok;
        retire  = m_valid && ready;
        allow   = !m_valid || ready;
        ref_wb(m_op, m_res, rd, d, s);
        if (retire && m_gw)
            sb.push_back('{addr: m_dest, strb: s, data: d, pc: m_pc});

        @(negedge clk);
        bv    = m_valid && m_gw && (m_dest != 5'd0);
        stall = bv && is_load && (!ok || m_op == 3'd6 || m_op == 3'd7);
        chk("allow_in", 32'(wb_allow_in), 32'(allow));
        chk("bypass_valid", 32'(wb_bypass_valid), 32'(bv));
        chk("bypass_stall", 32'(wb_bypass_stall), 32'(stall));
        if (bv) chk("bypass_dest", 32'(wb_bypass_dest), 32'(m_dest));
        if (bv && ready) chk("bypass_data", wb_bypass_data, d);

        if (rst) begin
            m_valid = 1'b0; m_pc = '0; m_dest = '0; m_gw = 1'b0; m_res = '0; m_op = '0;
        end else if (allow) begin
            m_valid = v;
            if (v) begin
                m_pc = pc; m_dest = dest; m_gw = gw; m_res = res; m_op = op;
            end
        end
    endtask

    task automatic idle(input logic ok);
        cycle(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 3'd0, ok, $urandom);
    endtask

    // Monitor: every write the DUT presents must match the oldest expectation.
    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (done) break;
            if (write_enabled !== 1'b0) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write at %0t",
                             write_address, write_data, $time);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr",  32'(write_address),   32'(e.addr));
                    chk("wr_strb",  32'(write_strobe),    32'(e.strb));
                    chk("wr_data",  write_data,           e.data);
                    chk("dbg_pc",   debug_wb_pc,          e.pc);
                    chk("dbg_wen",  32'(debug_wb_rf_wen), 32'(e.strb));
                    chk("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(e.addr));
                    chk("dbg_wdata", debug_wb_rf_wdata,   e.data);
                end
            end else begin
                chk("dbg_wen_idle", 32'(debug_wb_rf_wen), 32'h0);
            end
        end
    end

    initial begin
        reset = 1'b1; mem_to_wb_valid = 1'b0; mem_pc = '0; mem_dest = '0;
        mem_gpr_write = 1'b0; mem_result = '0; mem_load_op = '0;
        data_data_ok = 1'b0; data_rdata = '0;
        m_valid = 1'b0; m_pc = '0; m_dest = '0; m_gw = 1'b0; m_res = '0; m_op = '0;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        // Reset state, with a stray SRAM response present.
        cycle(1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 3'd0, 1'b1, 32'hDEADBEEF);
        chk("rst_wen",   32'(write_enabled), 32'h0);
        chk("rst_pc",    debug_wb_pc, 32'h0);
        chk("rst_wnum",  32'(debug_wb_rf_wnum), 32'h0);
        chk("rst_wdata", debug_wb_rf_wdata, 32'h0);
        chk("rst_bdata", wb_bypass_data, 32'h0);

        // Three back-to-back non-loads.
        cycle(1'b0, 1'b1, 32'h100, 5'd3, 1'b1, 32'h11, 3'd0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h104, 5'd4, 1'b1, 32'h22, 3'd0, 1'b0, 32'h0);
        chk("b2b_1", write_data, 32'h11);
        cycle(1'b0, 1'b1, 32'h108, 5'd5, 1'b1, 32'h33, 3'd0, 1'b0, 32'h0);
        chk("b2b_2", write_data, 32'h22);
        idle(1'b0);
        chk("b2b_3", write_data, 32'h33);

        // LB a=2 waiting three cycles for the SRAM.
        cycle(1'b0, 1'b1, 32'h200, 5'd7, 1'b1, 32'h1000_0002, 3'd1, 1'b0, 32'h0);
        repeat (3) cycle(1'b0, 1'b1, 32'h204, 5'd9, 1'b1, 32'h5, 3'd0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 3'd0, 1'b1, 32'h1280_FF00);
        chk("lb_data", write_data, 32'hFFFF_FF80);
        chk("lb_strb", 32'(write_strobe), 32'hF);

        // LWL a=1 followed directly by LWR a=2.
        cycle(1'b0, 1'b1, 32'h300, 5'd8, 1'b1, 32'h2000_0001, 3'd6, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h304, 5'd8, 1'b1, 32'h2000_0002, 3'd7, 1'b1, 32'hAABB_CCDD);
        chk("lwl_data",  write_data, 32'hCCDD_0000);
        chk("lwl_strb",  32'(write_strobe), 32'hC);
        chk("lwl_stall", 32'(wb_bypass_stall), 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 3'd0, 1'b1, 32'hAABB_CCDD);
        chk("lwr_data",  write_data, 32'h0000_AABB);
        chk("lwr_strb",  32'(write_strobe), 32'h3);
        chk("lwr_stall", 32'(wb_bypass_stall), 32'h1);

        // Non-load to $0.
        cycle(1'b0, 1'b1, 32'h400, 5'd0, 1'b1, 32'h77, 3'd0, 1'b0, 32'h0);
        idle(1'b0);
        chk("r0_wen",  32'(write_enabled), 32'h1);
        chk("r0_addr", 32'(write_address), 32'h0);
        chk("r0_bv",   32'(wb_bypass_valid), 32'h0);

        // Reset while a load waits; the later response must be ignored.
        cycle(1'b0, 1'b1, 32'h500, 5'd10, 1'b1, 32'h0, 3'd5, 1'b0, 32'h0);
        idle(1'b0);
        cycle(1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
        idle(1'b1);
        chk("rstw_wen",   32'(write_enabled), 32'h0);
        chk("rstw_dbg",   32'(debug_wb_rf_wen), 32'h0);
        chk("rstw_allow", 32'(wb_allow_in), 32'h1);

        // LHU / LH a=2.
        cycle(1'b0, 1'b1, 32'h600, 5'd11, 1'b1, 32'h3000_0002, 3'd4, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h604, 5'd12, 1'b1, 32'h3000_0002, 3'd3, 1'b1, 32'h8001_0000);
        chk("lhu_data", write_data, 32'h0000_8001);
        cycle(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 3'd0, 1'b1, 32'h8001_0000);
        chk("lh_data", write_data, 32'hFFFF_8001);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            cycle(1'b0, ($urandom_range(0, 3) != 0), $urandom,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                  ($urandom_range(0, 5) != 0), $urandom, op,
                  ($urandom_range(0, 1) == 1), $urandom);
        end

        // Drain: keep the SRAM responding until any held load retires.
        repeat (4) idle(1'b1);
        @(posedge clk);
        done = 1'b1;
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
